// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and counter width for the memory arbiter
package mem_arb_pkg;
  localparam int CW = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant select; MEM_ARB_RR_EN gives round-robin, otherwise data-over-fetch priority
module mem_arb_pick import mem_arb_pkg::*; (
  input  logic   if_req,
  input  logic   dm_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t last,
`endif
  output owner_t win
);
`ifdef MEM_ARB_RR_EN
  assign win = (if_req & dm_req) ? (last == OWN_DM ? OWN_IF : OWN_DM) : (dm_req ? OWN_DM : OWN_IF);
`else
  // with no request the pick is irrelevant, so fetch only wins when data is idle
  assign win = (dm_req || !if_req) ? OWN_DM : OWN_IF;
`endif
endmodule

// File: rtl/mem_arb.sv
// mem_arb: single-port fixed-latency memory arbiter for fetch and load/store; MEM_ARB_RR_EN enables round-robin
module mem_arb import mem_arb_pkg::*; #(
  parameter int LATENCY = 2,
  parameter int AW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [31:0]   o_if_rdata,
  output logic          o_if_vld,
  input  logic          i_flush,
  input  logic          i_dm_ren,
  input  logic          i_dm_wen,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [31:0]   i_dm_wdata,
  input  logic [3:0]    i_dm_mask,
  output logic [31:0]   o_dm_rdata,
  output logic          o_dm_vld,
  output logic          o_if_stall,
  output logic          o_dm_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic [3:0]    o_mem_mask,
  input  logic [31:0]   i_mem_rdata
);
  state_t state;
  owner_t owner, win;
  logic [CW-1:0] cnt;
  logic kill, wr, grant;
`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
`endif
  assign o_if_stall = i_if_req & ~o_if_vld;
  assign o_dm_stall = (i_dm_ren | i_dm_wen) & ~o_dm_vld;
  // stall doubles as "still pending": a requester completing in RESP is not re-granted
  mem_arb_pick u_pick (
    .if_req(o_if_stall),
    .dm_req(o_dm_stall),
`ifdef MEM_ARB_RR_EN
    .last(last_grant),
`endif
    .win(win)
  );
  assign grant = ~i_rst & (state != WAIT) & (o_if_stall | o_dm_stall);
  assign o_mem_req = grant;
  assign o_mem_we = grant & (win == OWN_DM) & i_dm_wen;
  assign o_mem_addr = !grant ? '0 : (win == OWN_DM ? i_dm_addr : i_if_addr);
  assign o_mem_wdata = o_mem_we ? i_dm_wdata : '0;
  assign o_mem_mask = !grant ? 4'h0 : (o_mem_we ? i_dm_mask : 4'hf);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      cnt <= '0;
      kill <= 1'b0;
      wr <= 1'b0;
      o_if_rdata <= '0;
      o_if_vld <= 1'b0;
      o_dm_rdata <= '0;
      o_dm_vld <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= OWN_IF;
`endif
    end else begin
      o_if_vld <= 1'b0;
      o_dm_vld <= 1'b0;
      if (state == WAIT) begin
        kill <= kill | (i_flush & (owner == OWN_IF));
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          state <= RESP;
          if (owner == OWN_DM) begin
            o_dm_vld <= 1'b1;
            if (!wr) o_dm_rdata <= i_mem_rdata;
          end else if (!(kill | i_flush)) begin
            o_if_vld <= 1'b1;
            o_if_rdata <= i_mem_rdata;
          end
        end
      end else if (grant) begin
        state <= WAIT;
        owner <= win;
        wr <= o_mem_we;
        cnt <= CW'(LATENCY - 1);
        kill <= i_flush & (win == OWN_IF);
`ifdef MEM_ARB_RR_EN
        last_grant <= win;
`endif
      end else begin
        state <= IDLE;
        kill <= 1'b0;
      end
    end
  end
endmodule
